// File: rtl/versatile_mem_ctrl_ddr_rd_capture.sv
// ============================================================================
// Module  : versatile_mem_ctrl_ddr_rd_capture
// Brief   : DDR2 read-return capture. Delays READ tokens by CAS + PHY latency,
//           samples BL/2 words and queues them in a small FWFT FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module versatile_mem_ctrl_ddr_rd_capture #(
    parameter int DW      = 32,
    parameter int CL_MAX  = 7,
    parameter int RX_LAT  = 2,
    parameter int FIFO_AW = 3
) (
    input  logic          clk_0,
    input  logic          rst_n,
    input  logic          rd_cmd_i,
    input  logic          bl8_i,
    input  logic [2:0]    cl_i,
    input  logic [DW-1:0] rx_dat_i,
    output logic [DW-1:0] rd_dat_o,
    output logic          rd_last_o,
    output logic          rd_vld_o,
    input  logic          rd_rdy_i,
    output logic          busy_o,
    output logic          ovf_o,
    output logic          ovl_o
);

    localparam int PL    = CL_MAX + RX_LAT;
    localparam int PW    = $clog2(PL);
    localparam int DEPTH = 2 ** FIFO_AW;

    logic [PL-1:1]    tok_vld_q, tok_bl8_q;
    logic [PL-1:0]    tok_vld_w, tok_bl8_w;
    logic [PW-1:0]    tap_idx_w;
    logic             arrive_w, arr_bl8_w;
    logic [2:0]       len_w;
    logic [2:0]       cnt_q, cnt_d;
    logic             push_w, last_w, ovl_d;
    logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
    logic [DW:0]      mem_q [0:DEPTH-1];
    logic [DW:0]      hold_q, head_w;
    logic             empty_w, full_w, pop_w, push_ok_w, drop_w;
    logic             ovf_q, ovl_q;

    // Stage 0 of the token pipe is the live command input itself.
    assign tok_vld_w = {tok_vld_q, rd_cmd_i};
    assign tok_bl8_w = {tok_bl8_q, bl8_i};
    assign tap_idx_w = PW'(cl_i) + PW'(RX_LAT - 1);
    assign arrive_w  = tok_vld_w[tap_idx_w];
    assign arr_bl8_w = tok_bl8_w[tap_idx_w];
    assign len_w     = arr_bl8_w ? 3'd4 : 3'd2;

    always_comb begin
        cnt_d  = cnt_q;
        push_w = 1'b0;
        last_w = 1'b0;
        ovl_d  = ovl_q;
        if (cnt_q == 3'd0) begin
            if (arrive_w) cnt_d = len_w;
        end else begin
            push_w = 1'b1;
            last_w = (cnt_q == 3'd1);
            if (cnt_q == 3'd1) begin
                cnt_d = arrive_w ? len_w : 3'd0;
            end else begin
                cnt_d = cnt_q - 3'd1;
                if (arrive_w) ovl_d = 1'b1;
            end
        end
    end

    assign empty_w   = (wr_ptr_q == rd_ptr_q);
    assign full_w    = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign pop_w     = ~empty_w & rd_rdy_i;
    assign push_ok_w = push_w & (~full_w | pop_w);
    assign drop_w    = push_w & full_w & ~pop_w;
    assign head_w    = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    always_ff @(posedge clk_0) begin
        if (push_ok_w) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {last_w, rx_dat_i};
    end

    always_ff @(posedge clk_0 or negedge rst_n) begin
        if (!rst_n) begin
            tok_vld_q <= '0;
            tok_bl8_q <= '0;
            cnt_q     <= 3'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            hold_q    <= '0;
            ovf_q     <= 1'b0;
            ovl_q     <= 1'b0;
        end else begin
            tok_vld_q <= tok_vld_w[PL-2:0];
            tok_bl8_q <= tok_bl8_w[PL-2:0];
            cnt_q     <= cnt_d;
            ovl_q     <= ovl_d;
            if (push_ok_w) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                hold_q   <= head_w;
            end
            if (drop_w) ovf_q <= 1'b1;
        end
    end

    // With the FIFO empty the outputs keep showing the last word handed out.
    assign rd_vld_o  = ~empty_w;
    assign rd_dat_o  = empty_w ? hold_q[DW-1:0] : head_w[DW-1:0];
    assign rd_last_o = empty_w ? hold_q[DW]     : head_w[DW];
    assign busy_o    = (|tok_vld_q) | (cnt_q != 3'd0) | ~empty_w;
    assign ovf_o     = ovf_q;
    assign ovl_o     = ovl_q;

endmodule

`default_nettype wire

// File: tb/tb_versatile_mem_ctrl_ddr_rd_capture.sv
// ============================================================================
// Module  : tb_versatile_mem_ctrl_ddr_rd_capture
// Brief   : Scoreboard bench; rx_dat_i carries the number of the edge sampling it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_versatile_mem_ctrl_ddr_rd_capture;

    localparam int DW     = 32;
    localparam int RX_LAT = 2;

    logic          clk_0 = 1'b0;
    logic          rst_n;
    logic          rd_cmd_i;
    logic          bl8_i;
    logic [2:0]    cl_i;
    logic [DW-1:0] rx_dat_i;
    logic [DW-1:0] rd_dat_o;
    logic          rd_last_o;
    logic          rd_vld_o;
    logic          rd_rdy_i;
    logic          busy_o;
    logic          ovf_o;
    logic          ovl_o;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [DW:0] exp_q [$];

    versatile_mem_ctrl_ddr_rd_capture #(
        .DW(DW), .CL_MAX(7), .RX_LAT(RX_LAT), .FIFO_AW(3)
    ) dut (
        .clk_0(clk_0), .rst_n(rst_n), .rd_cmd_i(rd_cmd_i), .bl8_i(bl8_i),
        .cl_i(cl_i), .rx_dat_i(rx_dat_i), .rd_dat_o(rd_dat_o),
        .rd_last_o(rd_last_o), .rd_vld_o(rd_vld_o), .rd_rdy_i(rd_rdy_i),
        .busy_o(busy_o), .ovf_o(ovf_o), .ovl_o(ovl_o)
    );

    always #5 clk_0 = ~clk_0;
    always @(posedge clk_0) cyc <= cyc + 1;
    assign rx_dat_i = DW'(cyc + 1);

    // Monitor: every accepted head word is matched against the scoreboard.
    always @(negedge clk_0) begin
        if (rst_n && rd_vld_o && rd_rdy_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL word_unexpected: got last=%0b dat=%0d, required none", rd_last_o, rd_dat_o);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                if ({rd_last_o, rd_dat_o} !== e) begin
                    n_err++;
                    $display("FAIL word: got last=%0b dat=%0d, required last=%0b dat=%0d",
                             rd_last_o, rd_dat_o, e[DW], e[DW-1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk_0);
    endtask

    // Command sampled at the next edge T; its words are captured from edge T+cl+RX_LAT.
    task automatic issue(input bit bl8, input int n_exp, input int gap);
        int t;
        int len;
        t        = cyc + 1;
        len      = bl8 ? 4 : 2;
        rd_cmd_i = 1'b1;
        bl8_i    = bl8;
        for (int i = 0; i < n_exp; i++)
            exp_q.push_back({(i == len - 1), DW'(t + int'(cl_i) + RX_LAT + i)});
        @(negedge clk_0);
        rd_cmd_i = 1'b0;
        bl8_i    = 1'b0;
        repeat (gap - 1) @(negedge clk_0);
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge clk_0);
            k++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        k = 0;
        while (busy_o && k < 50) begin
            @(negedge clk_0);
            k++;
        end
        chk({name, "_idle"}, 64'(busy_o), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk_0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_0);
        rst_n = 1'b1;
    endtask

    initial begin
        int t1;
        rst_n = 1'b0; rd_cmd_i = 1'b0; bl8_i = 1'b0; cl_i = 3'd3; rd_rdy_i = 1'b0;
        repeat (3) @(negedge clk_0);
        chk("rst_vld", 64'(rd_vld_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        rst_n = 1'b1;

        // Single BL4, CL3, command at edge 10.
        wait_cyc(9);
        rd_rdy_i = 1'b1;
        issue(1'b0, 2, 1);
        wait_cyc(14); chk("bl4_vld_e14", 64'(rd_vld_o), 64'd0);
        wait_cyc(15); chk("bl4_vld_e15", 64'(rd_vld_o), 64'd1);
                      chk("bl4_dat_e15", 64'(rd_dat_o), 64'd15);
        wait_cyc(16); chk("bl4_last_e16", 64'({rd_vld_o, rd_last_o}), 64'd3);
        wait_cyc(17); chk("bl4_vld_e17", 64'(rd_vld_o), 64'd0);
                      chk("bl4_hold", 64'({rd_last_o, rd_dat_o}), {31'd0, 1'b1, 32'd16});
        drain("bl4_drain");

        // BL8 then BL4 seamless: the second command trails by the BL8 data length.
        cl_i = 3'd4;
        issue(1'b1, 4, 4);
        issue(1'b0, 2, 1);
        drain("b2b_drain");
        chk("b2b_ovl", 64'(ovl_o), 64'd0);

        // Two BL8 one cycle apart: second token overlaps and is dropped.
        issue(1'b1, 4, 1);
        issue(1'b1, 0, 1);
        drain("ovl_drain");
        chk("ovl_set", 64'(ovl_o), 64'd1);
        chk("ovl_noovf", 64'(ovf_o), 64'd0);
        do_reset();
        chk("ovl_cleared", 64'(ovl_o), 64'd0);

        // Twelve pushes into an undrained 8-deep FIFO.
        rd_rdy_i = 1'b0;
        cl_i = 3'd3;
        issue(1'b1, 4, 4);
        issue(1'b1, 4, 4);
        issue(1'b1, 0, 4);
        repeat (12) @(negedge clk_0);
        chk("ovf_set", 64'(ovf_o), 64'd1);
        chk("ovf_vld", 64'(rd_vld_o), 64'd1);
        chk("ovf_noovl", 64'(ovl_o), 64'd0);
        rd_rdy_i = 1'b1;
        drain("ovf_drain");
        do_reset();

        // Fill the FIFO, then pop from edge T+12 while pushes continue into a full FIFO.
        rd_rdy_i = 1'b0;
        cl_i = 3'd2;
        t1 = cyc + 1;
        issue(1'b1, 4, 4);
        issue(1'b1, 4, 4);
        issue(1'b1, 4, 4);
        wait_cyc(t1 + 11);
        rd_rdy_i = 1'b1;
        drain("full_drain");
        chk("full_noovf", 64'(ovf_o), 64'd0);
        chk("full_noovl", 64'(ovl_o), 64'd0);

        // Async reset in the middle of a capture with data queued and ovl set.
        rd_rdy_i = 1'b0;
        cl_i = 3'd3;
        t1 = cyc + 1;
        issue(1'b1, 0, 1);
        issue(1'b1, 0, 1);
        wait_cyc(t1 + 7);
        chk("mid_vld", 64'(rd_vld_o), 64'd1);
        chk("mid_ovl", 64'(ovl_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs", 64'({rd_vld_o, rd_last_o, busy_o, ovf_o, ovl_o}), 64'd0);
        chk("arst_dat", 64'(rd_dat_o), 64'd0);
        @(negedge clk_0);
        @(negedge clk_0);
        rst_n = 1'b1;
        rd_rdy_i = 1'b1;
        repeat (12) @(negedge clk_0);
        chk("post_busy", 64'(busy_o), 64'd0);
        chk("post_vld", 64'(rd_vld_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
